// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-address generator: default widths,
// reset vector, the address type and the next-pc selection encoding.
package pc_pkg;

  localparam int          WIDTH        = 32;
  localparam int          STEP         = 4;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  typedef logic [WIDTH-1:0] addr_t;

  // Which source feeds the pc register on the next rising edge.
  // Reset is handled directly in the register process, so it is not
  // part of this selection.
  typedef enum logic [1:0] {
    SEL_HOLD    = 2'b00,
    SEL_ADVANCE = 2'b01,
    SEL_LOAD    = 2'b10
  } pc_sel_e;

  // True when a byte address is not on a 4-byte instruction boundary.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return (low_bits != 2'b00);
  endfunction

  // Clears the two byte-offset bits so the result is word-aligned.
  function automatic addr_t word_align(input addr_t addr);
    return {addr[WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_incrementer.sv
// Combinational next-sequential-address adder: sum = pc + STEP, wrapping
// modulo 2^WIDTH with no carry out.
module pc_incrementer
  import pc_pkg::*;
#(
  parameter int WIDTH = pc_pkg::WIDTH,
  parameter int STEP  = pc_pkg::STEP
) (
  input  logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] sum
);

  localparam logic [WIDTH-1:0] STEP_VEC = WIDTH'(STEP);

  // Unsigned add; the carry out of the top bit is deliberately dropped.
  always_comb begin
    sum = pc + STEP_VEC;
  end

endmodule

// File: rtl/program_counter.sv
// Registered instruction-address generator. Each rising edge the pc is
// reset, redirected to a load target, advanced by STEP, or held, in that
// priority order. pc_plus_step is the combinational sequential successor.
module program_counter
  import pc_pkg::*;
#(
  parameter int               WIDTH        = pc_pkg::WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(pc_pkg::RESET_VECTOR),
  parameter int               STEP         = pc_pkg::STEP
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_addr,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_step,
  output logic             misaligned
);

  logic [WIDTH-1:0] pc_r;
  logic             misaligned_r;
  logic [WIDTH-1:0] incr_s;
  logic [WIDTH-1:0] load_target_s;
  logic             load_misaligned_s;
  pc_sel_e          sel_s;
  logic [WIDTH-1:0] next_pc_s;
  logic             next_misaligned_s;

  pc_incrementer #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_incrementer (
    .pc  (pc_r),
    .sum (incr_s)
  );

  // Redirect target is forced onto a word boundary; the dropped offset
  // bits are reported through the misaligned flag instead.
  always_comb begin
    load_target_s     = {load_addr[WIDTH-1:2], 2'b00};
    load_misaligned_s = is_misaligned(load_addr[1:0]);
  end

  // Choose the pc source: a redirect wins over a sequential advance.
  always_comb begin
    sel_s = SEL_HOLD;
    if (load) begin
      sel_s = SEL_LOAD;
    end else if (enable) begin
      sel_s = SEL_ADVANCE;
    end else begin
      sel_s = SEL_HOLD;
    end
  end

  // Next-state values for pc and the misaligned flag from the selection.
  always_comb begin
    next_pc_s         = pc_r;
    next_misaligned_s = misaligned_r;
    case (sel_s)
      SEL_LOAD: begin
        next_pc_s         = load_target_s;
        next_misaligned_s = load_misaligned_s;
      end
      SEL_ADVANCE: begin
        next_pc_s         = incr_s;
        next_misaligned_s = 1'b0;
      end
      SEL_HOLD: begin
        next_pc_s         = pc_r;
        next_misaligned_s = misaligned_r;
      end
      default: begin
        next_pc_s         = pc_r;
        next_misaligned_s = misaligned_r;
      end
    endcase
  end

  // pc and misaligned registers; synchronous reset overrides load/enable.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc_r         <= RESET_VECTOR;
      misaligned_r <= 1'b0;
    end else begin
      pc_r         <= next_pc_s;
      misaligned_r <= next_misaligned_s;
    end
  end

  assign pc           = pc_r;
  assign misaligned   = misaligned_r;
  assign pc_plus_step = incr_s;

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: a driver applies directed and
// random stimulus on the falling edge, a reference model predicts the
// state after the next rising edge and queues it, and a monitor compares
// the DUT outputs just after every rising edge.
module tb_program_counter;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic        load;
  logic [31:0] load_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus_step;
  logic        misaligned;

  typedef struct {
    logic [31:0] pc;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (plain arithmetic, 64-bit to make the wrap explicit)
  longint unsigned m_pc  = 0;
  bit              m_mis = 1'b0;

  program_counter dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .load         (load),
    .load_addr    (load_addr),
    .pc           (pc),
    .pc_plus_step (pc_plus_step),
    .misaligned   (misaligned)
  );

  initial begin
    clock = 1'b0;
    forever #100 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at time %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at the falling edge, predict the post-edge state.
  task automatic cycle(input bit rst_n, input bit ld, input logic [31:0] addr, input bit en);
    exp_t e;
    @(negedge clock);
    reset_n   = rst_n;
    load      = ld;
    load_addr = addr;
    enable    = en;
    if (!rst_n) begin
      m_pc  = 0;
      m_mis = 1'b0;
    end else if (ld) begin
      m_pc  = (longint'(addr) / 4) * 4;
      m_mis = (addr % 4) != 0;
    end else if (en) begin
      m_pc  = (m_pc + 4) % 64'h1_0000_0000;
      m_mis = 1'b0;
    end
    e.pc  = m_pc[31:0];
    e.mis = m_mis;
    exp_q.push_back(e);
  endtask

  // Monitor: compare outputs shortly after each rising edge.
  initial begin
    exp_t e;
    logic [31:0] succ;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        succ = 32'((longint'(e.pc) + 4) % 64'h1_0000_0000);
        check("pc", pc, e.pc);
        check("misaligned", {31'd0, misaligned}, {31'd0, e.mis});
        check("pc_plus_step", pc_plus_step, succ);
      end
    end
  end

  initial begin
    logic [31:0] a;
    int r;
    reset_n   = 1'b0;
    enable    = 1'b0;
    load      = 1'b0;
    load_addr = 32'h0;

    // Reset, then count up to 16
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    // Stall at 16
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0);
    // Continue to 40
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    // Reset together with load and enable
    cycle(1'b0, 1'b1, 32'h0000_2000, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    // Misaligned load, hold keeps the flag, then advance clears it
    cycle(1'b1, 1'b1, 32'h0000_1003, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    // Load wins over enable, then wrap through zero
    cycle(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFF0 | (a & 32'hF);
      cycle((r >= 3), ($urandom_range(0, 3) == 0), a, ($urandom_range(0, 9) < 6));
    end

    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    @(posedge clock);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
